// File: rtl/max_unpool_stream.sv
// Streaming max-unpool: expands each pooled value into an N-slot window behind a 2-entry skid FIFO.
// Define UNPOOL_FILL_NEAREST_EN to replicate the value into every slot instead (nearest-neighbour).
module max_unpool_stream #(
    parameter int unsigned N           = 4,
    parameter int unsigned DATA_WIDTH  = 13,
    parameter int unsigned ROW_WINDOWS = 16,
    localparam int unsigned INDEX_WIDTH = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [INDEX_WIDTH-1:0]  in_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH*N-1:0] out_data,
    output logic                    out_last,
    output logic                    idx_err
);

    localparam int unsigned CNT_WIDTH = (ROW_WINDOWS > 1) ? $clog2(ROW_WINDOWS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ROW_WINDOWS - 1);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

    occ_e                  occ_q, occ_d;
    logic                  in_ready_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  push, pop, row_end;
    logic [DATA_WIDTH-1:0] head_data;

    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != StEmpty);
    assign row_end   = (cnt_q == LAST_CNT);
    assign out_last  = row_end && out_valid;
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            StEmpty: if (push) occ_d = StOne;
            StOne: begin
                if (push && !pop)      occ_d = StFull;
                else if (pop && !push) occ_d = StEmpty;
            end
            StFull:  if (pop) occ_d = StOne;
            default: occ_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= StEmpty;
            in_ready_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            data_q     <= '{default: '0};
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= (occ_d != StFull);
            if (push) begin
                data_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                cnt_q    <= row_end ? '0 : cnt_q + 1'b1;
            end
        end
    end

`ifdef UNPOOL_FILL_NEAREST_EN
    logic unused_index;
    assign unused_index = ^in_index;
    assign idx_err      = 1'b0;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign out_data[DATA_WIDTH*(N-k)-1 -: DATA_WIDTH] = out_valid ? head_data : '0;
    end
`else
    localparam logic [INDEX_WIDTH:0] NUM_SLOTS = (INDEX_WIDTH+1)'(N);

    logic [INDEX_WIDTH-1:0] index_q [2];
    logic                   idx_err_q;
    logic [INDEX_WIDTH-1:0] head_index;

    assign head_index = index_q[rd_ptr_q];
    assign idx_err    = idx_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            index_q   <= '{default: '0};
            idx_err_q <= 1'b0;
        end else if (push) begin
            index_q[wr_ptr_q] <= in_index;
            // Sticky: an out-of-range slot can only exist when N is not a power of two.
            if ({1'b0, in_index} >= NUM_SLOTS) idx_err_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        localparam logic [INDEX_WIDTH-1:0] SLOT = INDEX_WIDTH'(k);
        assign out_data[DATA_WIDTH*(N-k)-1 -: DATA_WIDTH] =
            (out_valid && head_index == SLOT) ? head_data : '0;
    end
`endif

endmodule

// File: tb/tb_max_unpool_stream.sv
// Bench for max_unpool_stream: two instances (N=4/ROW_WINDOWS=4 and N=3/ROW_WINDOWS=5) on shared
// stimulus, checked every cycle against a queue-based model plus literal spot checks.
module tb_max_unpool_stream;
    localparam int DW = 13;
    localparam int NA = 4;
    localparam int NB = 3;
    localparam int RA = 4;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0] in_index = '0;
    logic out_ready = 1'b0;

    logic a_in_ready, a_out_valid, a_out_last, a_idx_err;
    logic b_in_ready, b_out_valid, b_out_last, b_idx_err;
    logic [DW*NA-1:0] a_out_data;
    logic [DW*NB-1:0] b_out_data;

    always #5 clk = ~clk;

    max_unpool_stream #(.N(NA), .DATA_WIDTH(DW), .ROW_WINDOWS(RA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_index(in_index), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .idx_err(a_idx_err)
    );

    max_unpool_stream #(.N(NB), .DATA_WIDTH(DW), .ROW_WINDOWS(RB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_index(in_index), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .idx_err(b_idx_err)
    );

    int tests = 0;
    int fails = 0;

    // Model: FIFO contents as {data, index}, plus per-instance row counter and sticky error.
    logic [DW+1:0] q[$];
    int cnt[2];
    bit err[2];
    bit rst_flag;
    int nn[2] = '{NA, NB};
    int rows[2] = '{RA, RB};

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [103:0] exp_data(int n, logic [DW-1:0] d, logic [1:0] ix);
        logic [103:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
`ifdef UNPOOL_FILL_NEAREST_EN
            r[DW*(n-1-k) +: DW] = d;
`else
            if (int'(ix) == k) r[DW*(n-1-k) +: DW] = d;
`endif
        end
        return r;
    endfunction

    task automatic compare_all();
        for (int u = 0; u < 2; u++) begin
            bit vld, rdy;
            logic [103:0] ed;
            vld = q.size() > 0;
            rdy = !rst_flag && q.size() < 2;
            ed  = vld ? exp_data(nn[u], q[0][DW+1:2], q[0][1:0]) : '0;
            if (u == 0) begin
                chk("a_in_ready", a_in_ready, rdy);
                chk("a_out_valid", a_out_valid, vld);
                chk("a_out_data", a_out_data, ed);
                chk("a_out_last", a_out_last, vld && cnt[0] == rows[0] - 1);
                chk("a_idx_err", a_idx_err, err[0]);
            end else begin
                chk("b_in_ready", b_in_ready, rdy);
                chk("b_out_valid", b_out_valid, vld);
                chk("b_out_data", b_out_data, ed);
                chk("b_out_last", b_out_last, vld && cnt[1] == rows[1] - 1);
                chk("b_idx_err", b_idx_err, err[1]);
            end
        end
    endtask

    task automatic model_update(input bit v, input logic [DW-1:0] d, input logic [1:0] ix,
                                input bit ordy, input bit r);
        bit push, pop;
        if (r) begin
            q.delete();
            cnt = '{0, 0};
            err = '{0, 0};
            rst_flag = 1'b1;
            return;
        end
        pop  = q.size() > 0 && ordy;
        push = v && !rst_flag && q.size() < 2;
        if (pop) begin
            void'(q.pop_front());
            for (int u = 0; u < 2; u++) cnt[u] = (cnt[u] == rows[u] - 1) ? 0 : cnt[u] + 1;
        end
        if (push) begin
            q.push_back({d, ix});
`ifndef UNPOOL_FILL_NEAREST_EN
            for (int u = 0; u < 2; u++) if (int'(ix) >= nn[u]) err[u] = 1'b1;
`endif
        end
        rst_flag = 1'b0;
    endtask

    // Called just after a falling edge: check, drive, clock, advance the model.
    task automatic step(input bit v, input logic [DW-1:0] d, input logic [1:0] ix,
                        input bit ordy, input bit r);
        compare_all();
        in_valid = v; in_data = d; in_index = ix; out_ready = ordy; rst = r;
        @(posedge clk);
        model_update(v, d, ix, ordy, r);
        @(negedge clk);
    endtask

    initial begin
        cnt = '{0, 0};
        err = '{0, 0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_flag = 1'b1;

        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_data", a_out_data, '0);
        chk("rst_out_last", a_out_last, 1'b0);
        chk("rst_idx_err", b_idx_err, 1'b0);
        step(0, 0, 0, 1, 0);
        chk("ready_after_rst", a_in_ready, 1'b1);

`ifdef UNPOOL_FILL_NEAREST_EN
        step(1, 13'h012, 1, 1, 0);
        chk("nearest_data", a_out_data, {4{13'h012}});
        chk("nearest_err", a_idx_err, 1'b0);
        step(0, 0, 0, 1, 0);
`else
        step(1, 13'h0A5, 2, 1, 0);
        chk("basic_valid", a_out_valid, 1'b1);
        chk("basic_data", a_out_data, {13'h0, 13'h0, 13'h0A5, 13'h0});
        chk("basic_ready", a_in_ready, 1'b1);
        step(1, 13'h1FFF, 0, 1, 0);
        chk("neg_data_a", a_out_data, {13'h1FFF, 39'h0});
        chk("neg_data_b", b_out_data, {13'h1FFF, 26'h0});
        step(0, 0, 0, 1, 0);
        chk("drained", a_out_valid, 1'b0);

        step(1, 13'h101, 1, 0, 0);
        chk("bp_ready_one", a_in_ready, 1'b1);
        step(1, 13'h102, 2, 0, 0);
        chk("bp_ready_full", a_in_ready, 1'b0);
        chk("bp_hold1", a_out_data, {13'h0, 13'h101, 26'h0});
        step(1, 13'h103, 3, 0, 0);
        chk("bp_ready_still", a_in_ready, 1'b0);
        chk("bp_hold2", a_out_data, {13'h0, 13'h101, 26'h0});
        step(0, 0, 0, 1, 0);
        chk("bp_second", a_out_data, {26'h0, 13'h102, 13'h0});
        chk("bp_ready_back", a_in_ready, 1'b1);
        step(0, 0, 0, 1, 0);
        chk("bp_empty", a_out_valid, 1'b0);

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            step(1, DW'(i), 0, 1, 0);
            chk("row_last_a", a_out_last, (i % RA) == 0);
            chk("row_last_b", b_out_last, (i % RB) == 0);
        end
        step(0, 0, 0, 1, 0);

        step(1, 13'h055, 3, 1, 0);
        chk("oor_valid", b_out_valid, 1'b1);
        chk("oor_data", b_out_data, '0);
        chk("oor_err", b_idx_err, 1'b1);
        chk("oor_a_data", a_out_data, {39'h0, 13'h055});
        chk("oor_a_err", a_idx_err, 1'b0);
        step(1, 13'h056, 1, 1, 0);
        chk("err_sticky", b_idx_err, 1'b1);
        chk("after_err_data", b_out_data, {13'h0, 13'h056, 13'h0});
        step(1, 13'h001, 1, 0, 0);
        step(1, 13'h002, 2, 0, 0);
        chk("full_before_rst", b_in_ready, 1'b0);
        step(0, 0, 0, 0, 1);
        chk("rst_mid_valid", b_out_valid, 1'b0);
        chk("rst_mid_err", b_idx_err, 1'b0);
        chk("rst_mid_last", a_out_last, 1'b0);
        step(0, 0, 0, 1, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, DW'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end
        compare_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/max_unpool_stream.md
Name: max_unpool_stream

Overview:
- Inverse of the N-way pooling comparator.
- Accepts a stream of pooled values, each with the winning index the comparator produced. Emits one N-element window per value: the value sits at the indexed slot and every other slot holds zero.
- Sits in the decoder half of the encoder-decoder datapath. Feeds upsampled windows to the decoder convolution stage.
- Has valid/ready handshakes on both sides, a 2-entry skid buffer, and a per-row window counter.

Parameters:
- N, 4, window size (values per pooled element); legal 2..8.
- DATA_WIDTH, 13, bit width of each value (two's complement).
- ROW_WINDOWS, 16, windows per feature-map row; sets the out_last cadence; legal >= 1.
- INDEX_WIDTH, $clog2(N), localparam, width of the index field.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  pooled value and index present.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  DATA_WIDTH  pooled value.
- in_index  input  INDEX_WIDTH  slot to restore, 0..N-1.
- out_valid  output  1  output window valid.
- out_ready  input  1  downstream accepts the window.
- out_data  output  DATA_WIDTH*N  unpooled window; slot i occupies bits [DATA_WIDTH*(N-i)-1 : DATA_WIDTH*(N-1-i)], so slot 0 is the most-significant slice (same packing as the comparator input).
- out_last  output  1  marks the final window of a row.
- idx_err  output  1  sticky flag: an accepted index was >= N.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: in_ready=0 during the rst cycle and 1 from the first cycle after; out_valid=0; out_data=0; out_last=0; idx_err=0; occupancy=0; window counter=0.
- Input handshake: a transfer occurs when in_valid && in_ready. out_valid/out_ready handshake likewise.
- Buffer: 2-entry skid FIFO holding {data, index}. Occupancy states are EMPTY, ONE and FULL.
  - in_ready = (occupancy != FULL); registered, no combinational path from out_ready.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push without pop -> FULL.
  - ONE + pop without push -> EMPTY.
  - ONE + push and pop -> ONE.
  - FULL + pop -> ONE. No push is possible while FULL.
- Output stage: out_valid = (occupancy != EMPTY). out_data and out_last are driven from registered head-of-FIFO state; no combinational input-to-output path.
  - Latency: an input accepted in cycle t gives out_valid=1 in cycle t+1 when the buffer was empty.
  - Throughput: 1 window/cycle while out_ready is held high.
- Stall: while out_valid && !out_ready, out_data, out_last and out_valid hold stable.
- Window decode:
  - out_data slot k = head.data when head.index == k, else 0.
  - Value is copied bit-exact; no sign extension or arithmetic.
- Out-of-range index (only possible when N is not a power of 2): head.index >= N emits an all-zero window and sets idx_err. idx_err clears only on rst.
- Window counter:
  - Counts 0..ROW_WINDOWS-1 and increments on each output handshake.
  - out_last = (counter == ROW_WINDOWS-1) && out_valid.
  - Wraps to 0 on the handshake that carries out_last.
  - ROW_WINDOWS=1 gives out_last on every window.
- Reset mid-operation: buffered entries are discarded, counter returns to 0, and no partial window is emitted after reset.
- No ordering change: windows leave in acceptance order.

Optional Feature:
- Macro: UNPOOL_FILL_NEAREST_EN.
- Defined: nearest-neighbour upsampling. Every slot of out_data equals head.data and in_index is ignored for decode. idx_err is tied to 0 and the index is not stored in the buffer. Handshake, latency and counter behaviour are unchanged.
- Undefined: index-directed max-unpooling with zero fill, as described in Behaviour.

Test Plan:
- N=4, DATA_WIDTH=13, hold out_ready=1, push data=13'h0A5 with index=2 -> one cycle later out_valid=1 and out_data={13'h0, 13'h0, 13'h0A5, 13'h0}; in_ready stays 1.
- Negative value: push data=13'h1FFF (-1) with index=0 -> out_data[51:39]=13'h1FFF and all other bits 0.
- Backpressure: out_ready=0, push 3 values back-to-back -> 2 accepted and in_ready=0 from the cycle after the second; output holds the first window stable. Release out_ready -> windows come out in order, 1 per cycle, then in_ready returns to 1.
- ROW_WINDOWS=4, stream 9 windows with out_ready=1 -> out_last=1 on windows 4 and 8 only; the counter then reads 1 after window 9.
- N=3, push index=3 -> out_data=0 and idx_err=1 and stays 1 through later valid inputs until rst. Assert rst with 2 entries buffered -> the next cycle has out_valid=0 and counter 0.
- UNPOOL_FILL_NEAREST_EN defined, N=4: push data=13'h012 with index=1 -> out_data={4{13'h012}}, idx_err=0.
